dmem_responder: RTL

Data-memory responder for the Chronos core's MEM stage. It answers the load/store requests the pipeline issues with a valid/ready request channel and a valid/ready response channel. It supports RV32I byte, half and word accesses with sign or zero extension, a configurable response latency, and error reporting. It sits between the EX/MEM register and the MEM/WB register, and is the data-side counterpart of the core's fetch initiator.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 69 ++++++
 rtl/dmem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// and access-size helpers used by the responder and its lane aligner.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_X} size_t;

   // funct3[1:0] carries the access size for both loads and stores
   function automatic size_t size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    size_of = SZ_B;
         2'd1:    size_of = SZ_H;
         2'd2:    size_of = SZ_W;
         default: size_of = SZ_X;
      endcase
   endfunction

   function automatic logic f3_illegal(input logic write, input logic [2:0] f3);
      if (write) f3_illegal = (f3 >= 3'd3);
      else       f3_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables / replicated data, load lane
// extraction with sign or zero extension, and the misalignment flag.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   size_t       sz;

   assign sz    = size_of(funct3);
   assign rbyte = rword[8*addr_lo +: 8];
   assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      misaligned = 1'b0;
      case (sz)
         SZ_H:    misaligned = addr_lo[0];
         SZ_W:    misaligned = (addr_lo != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end

   // Data is replicated across lanes so the byte enables alone pick the target
   always_comb begin
      be       = 4'b0000;
      wdata_sh = 32'h0;
      case (sz)
         SZ_B: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
         end
         SZ_H: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
         end
         SZ_W: begin
            be       = 4'b1111;
            wdata_sh = wdata;
         end
         default: begin
            be       = 4'b0000;
            wdata_sh = 32'h0;
         end
      endcase
   end

   always_comb begin
      rdata_ext = 32'h0;
      case (funct3)
         F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
         F3_BU:   rdata_ext = {24'h0, rbyte};
         F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
         F3_HU:   rdata_ext = {16'h0, rhalf};
         F3_W:    rdata_ext = rword;
         default: rdata_ext = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory: single outstanding load/store with fixed response
// latency, error classification, and a valid/ready response channel.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_valid,
   output logic        mem_req_ready,
   input  logic [31:0] mem_req_addr,
   input  logic        mem_req_write,
   input  logic [2:0]  mem_req_funct3,
   input  logic [31:0] mem_req_wdata,
   output logic        mem_resp_valid,
   input  logic        mem_resp_ready,
   output logic [31:0] mem_resp_data,
   output logic        mem_resp_error
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [31:0] mem [DEPTH_WORDS];

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        accept, err, out_of_range, misaligned, wr_en;
   logic [AW-1:0] idx;
   logic [3:0]  be;
   logic [31:0] wdata_sh, rword, rdata_ext;

   assign mem_req_ready  = (state == IDLE);
   assign mem_resp_valid = (state == RESP);
   assign accept         = mem_req_valid & mem_req_ready;

   assign idx          = mem_req_addr[AW+1:2];
   assign out_of_range = ({2'b00, mem_req_addr[31:2]} >= 32'(DEPTH_WORDS));
   assign err          = misaligned | out_of_range | f3_illegal(mem_req_write, mem_req_funct3);
   assign rword        = out_of_range ? 32'h0 : mem[idx];

   dmem_lane_align u_align (
      .addr_lo    (mem_req_addr[1:0]),
      .funct3     (mem_req_funct3),
      .wdata      (mem_req_wdata),
      .rword      (rword),
      .be         (be),
      .wdata_sh   (wdata_sh),
      .rdata_ext  (rdata_ext),
      .misaligned (misaligned)
   );

   // Stores commit at acceptance so a following load sees the new data
   assign wr_en = rst & accept & mem_req_write & ~err;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         mem_resp_data  <= 32'h0;
         mem_resp_error <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            mem_resp_error <= err;
            mem_resp_data  <= (err || mem_req_write) ? 32'h0 : rdata_ext;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
                  cnt_nxt   = 4'd0;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            if (mem_resp_ready) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

endmodule
